// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: bus widths and FSM state codes.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_data_t;

  localparam reg_addr_t ZERO_REG  = '0;
  localparam reg_data_t ZERO_WORD = '0;

  typedef enum logic [1:0] {
    WB_ARB_IDLE  = 2'd0,
    WB_ARB_PEND  = 2'd1,
    WB_ARB_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of pipeline writeback, long-latency result, regfile write and hazard signals.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic      wb_we;
  reg_addr_t wb_waddr;
  reg_data_t wb_wdata;
  logic      lu_valid;
  logic      lu_ready;
  reg_addr_t lu_waddr;
  reg_data_t lu_wdata;
  logic      rf_we;
  reg_addr_t rf_waddr;
  reg_data_t rf_wdata;
  logic      stall_o;
  logic      pend_valid;
  reg_addr_t pend_addr;

  modport master (
    output wb_we, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, stall_o, pend_valid, pend_addr
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata,
    output lu_ready, rf_we, rf_waddr, rf_wdata, stall_o, pend_valid, pend_addr
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between in-order writeback (A) and a
// one-entry buffered long-latency result (B), with starvation-forced drains.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  reg_addr_t        buf_addr;
  reg_data_t        buf_data;

  assign cnt_inc = cnt + CNT_W'(1);

  // Outputs are combinational so port A reaches the regfile with no added latency.
  always_comb begin
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = ZERO_REG;
    bus.rf_wdata   = ZERO_WORD;
    bus.stall_o    = 1'b0;
    bus.lu_ready   = 1'b0;
    bus.pend_valid = 1'b0;
    bus.pend_addr  = ZERO_REG;
    if (!rst) begin
      case (state)
        WB_ARB_IDLE: begin
          bus.lu_ready = 1'b1;
          bus.rf_we    = bus.wb_we;
          bus.rf_waddr = bus.wb_waddr;
          bus.rf_wdata = bus.wb_wdata;
        end
        WB_ARB_PEND: begin
          bus.pend_valid = 1'b1;
          bus.pend_addr  = buf_addr;
          bus.rf_we      = 1'b1;
          if (bus.wb_we) begin
            bus.rf_waddr = bus.wb_waddr;
            bus.rf_wdata = bus.wb_wdata;
          end else begin
            bus.rf_waddr = buf_addr;
            bus.rf_wdata = buf_data;
          end
        end
        WB_ARB_FORCE: begin
          bus.stall_o    = 1'b1;
          bus.pend_valid = 1'b1;
          bus.pend_addr  = buf_addr;
          bus.rf_we      = 1'b1;
          bus.rf_waddr   = buf_addr;
          bus.rf_wdata   = buf_data;
        end
        default: ;
      endcase
    end
  end

  // Control: state, starvation counter and buffered destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WB_ARB_IDLE;
      cnt      <= '0;
      buf_addr <= ZERO_REG;
    end else begin
      case (state)
        WB_ARB_IDLE: begin
          // Results aimed at x0 are dropped so they never consume the port.
          if (bus.lu_valid && (bus.lu_waddr != ZERO_REG)) begin
            state    <= WB_ARB_PEND;
            cnt      <= '0;
            buf_addr <= bus.lu_waddr;
          end
        end
        WB_ARB_PEND: begin
          if (!bus.wb_we) begin
            state <= WB_ARB_IDLE;
          end else if (bus.wb_waddr == buf_addr) begin
            // Younger writeback owns the register; the buffered value is stale.
            state <= WB_ARB_IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
              state <= WB_ARB_FORCE;
            end
          end
        end
        WB_ARB_FORCE: begin
          state <= WB_ARB_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= WB_ARB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Data: buffered result payload, loaded only on an accepted result.
  always_ff @(posedge clk) begin
    if ((state == WB_ARB_IDLE) && bus.lu_valid) begin
      buf_data <= bus.lu_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural
// model of the pending-result / starvation rules.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: one pending result, how many times it was denied, and whether a forced drain is due.
  bit        m_pend;
  bit        m_force;
  reg_addr_t m_addr;
  reg_data_t m_data;
  int        m_denied;

  function automatic logic [45:0] exp_vec();
    logic we, st, rdy, pv;
    reg_addr_t a, pa;
    reg_data_t d;
    we = 1'b0; a = '0; d = '0; st = 1'b0; rdy = 1'b0; pv = 1'b0; pa = '0;
    if (!rst) begin
      if (m_force) begin
        st = 1'b1; we = 1'b1; a = m_addr; d = m_data; pv = 1'b1; pa = m_addr;
      end else if (m_pend) begin
        pv = 1'b1; pa = m_addr; we = 1'b1;
        if (bus.wb_we) begin a = bus.wb_waddr; d = bus.wb_wdata; end
        else begin a = m_addr; d = m_data; end
      end else begin
        rdy = 1'b1; we = bus.wb_we; a = bus.wb_waddr; d = bus.wb_wdata;
      end
    end
    return {we, a, d, st, rdy, pv, pa};
  endfunction

  function automatic logic [45:0] got_vec();
    return {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_o,
            bus.lu_ready, bus.pend_valid, bus.pend_addr};
  endfunction

  task automatic drive(input logic we, input reg_addr_t wa, input reg_data_t wd,
                       input logic lv, input reg_addr_t la, input reg_data_t ld);
    bus.wb_we    = we;
    bus.wb_waddr = wa;
    bus.wb_wdata = wd;
    bus.lu_valid = lv;
    bus.lu_waddr = la;
    bus.lu_wdata = ld;
  endtask

  // Advance one clock and apply the arbitration rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_pend = 1'b0; m_force = 1'b0; m_denied = 0;
    end else if (m_force) begin
      m_pend = 1'b0; m_force = 1'b0; m_denied = 0;
    end else if (m_pend) begin
      if (!bus.wb_we || bus.wb_waddr == m_addr) m_pend = 1'b0;
      else begin
        m_denied++;
        if (m_denied == STARVE_LIMIT) m_force = 1'b1;
      end
    end else if (bus.lu_valid && bus.lu_waddr != 5'd0) begin
      m_pend = 1'b1; m_addr = bus.lu_waddr; m_data = bus.lu_wdata; m_denied = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd9, 32'hCAFE, 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    checks++;
    if (got_vec() !== 46'd0) begin
      failures++; $display("FAIL reset_outputs: got %h required 0", got_vec());
    end
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.lu_ready !== 1'b1 || bus.pend_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release: got ready=%b pend=%b required 1 0", bus.lu_ready, bus.pend_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_pend();
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.pend_valid !== 1'b1 || bus.pend_addr !== 5'd5) begin
      failures++; $display("FAIL midrst_pend: got %b/%0d required 1/5", bus.pend_valid, bus.pend_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.pend_valid, bus.lu_ready} !== 3'b000) begin
      failures++; $display("FAIL midrst_during: got %b required 000", {bus.rf_we, bus.pend_valid, bus.lu_ready});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.lu_ready !== 1'b1 || bus.pend_valid !== 1'b0 || bus.rf_we !== 1'b0) begin
        failures++; $display("FAIL midrst_after%0d: got r=%b p=%b we=%b required 1 0 0", i, bus.lu_ready, bus.pend_valid, bus.rf_we);
      end
      tick();
    end
  endtask

  task automatic test_idle_drain();
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h1234);
    @(negedge clk);
    checks++;
    if (bus.lu_ready !== 1'b1) begin
      failures++; $display("FAIL drain_accept: got ready=%b required 1", bus.lu_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_o, bus.lu_ready} !== {1'b1, 5'd7, 32'h1234, 1'b0, 1'b0}) begin
      failures++; $display("FAIL drain_write: got we=%b a=%0d d=%h st=%b r=%b required 1 7 1234 0 0",
        bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_o, bus.lu_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.lu_ready !== 1'b1 || bus.pend_valid !== 1'b0) begin
      failures++; $display("FAIL drain_idle: got r=%b p=%b required 1 0", bus.lu_ready, bus.pend_valid);
    end
    tick();
  endtask

  task automatic test_port_a_priority();
    drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h3333);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd9, 32'h55, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_o} !== {1'b1, 5'd9, 32'h55, 1'b0}) begin
        failures++; $display("FAIL prio_a%0d: got a=%0d d=%h st=%b required 9 55 0", i, bus.rf_waddr, bus.rf_wdata, bus.stall_o);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_o} !== {1'b1, 5'd3, 32'h3333, 1'b0}) begin
      failures++; $display("FAIL prio_b: got a=%0d d=%h st=%b required 3 3333 0", bus.rf_waddr, bus.rf_wdata, bus.stall_o);
    end
    tick();
  endtask

  task automatic test_starvation();
    drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h33);
    tick();
    drive(1'b1, 5'd10, 32'h1010, 1'b0, '0, '0);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.stall_o} !== {1'b1, 5'd10, 1'b0}) begin
        failures++; $display("FAIL starve_a%0d: got a=%0d st=%b required 10 0", i, bus.rf_waddr, bus.stall_o);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_o, bus.pend_valid} !== {1'b1, 5'd3, 32'h33, 1'b1, 1'b1}) begin
      failures++; $display("FAIL starve_force: got a=%0d d=%h st=%b p=%b required 3 33 1 1",
        bus.rf_waddr, bus.rf_wdata, bus.stall_o, bus.pend_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_o, bus.lu_ready} !== {1'b1, 5'd10, 32'h1010, 1'b0, 1'b1}) begin
      failures++; $display("FAIL starve_replay: got a=%0d st=%b r=%b required 10 0 1", bus.rf_waddr, bus.stall_o, bus.lu_ready);
    end
    tick();
  endtask

  task automatic test_waw_squash();
    drive(1'b0, '0, '0, 1'b1, 5'd8, 32'hAAAA);
    tick();
    drive(1'b1, 5'd8, 32'hBBBB, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd8, 32'hBBBB}) begin
      failures++; $display("FAIL waw_young: got a=%0d d=%h required 8 BBBB", bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.pend_valid !== 1'b0 || bus.rf_we !== 1'b0) begin
        failures++; $display("FAIL waw_stale%0d: got p=%b we=%b d=%h required 0 0", i, bus.pend_valid, bus.rf_we, bus.rf_wdata);
      end
      tick();
    end
  endtask

  task automatic test_x0_discard();
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h7777);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.pend_valid, bus.lu_ready, bus.rf_we} !== 3'b010) begin
      failures++; $display("FAIL x0_discard: got p/r/we=%b required 010", {bus.pend_valid, bus.lu_ready, bus.rf_we});
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_c%0d: got %h required %h", i, got_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_pend = 1'b0; m_force = 1'b0; m_denied = 0; m_addr = '0; m_data = '0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    test_reset();
    test_reset_mid_pend();
    test_idle_drain();
    test_port_a_priority();
    test_starvation();
    test_waw_squash();
    test_x0_discard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (port A) and a long-latency unit such as a load/mul-div unit (port B, valid/ready).
- Port B results are held in a one-entry buffer. The buffer is drained into the regfile when port A leaves the write port free.
- A starvation counter forces a drain by stalling the pipeline for one cycle.
- Also exports the pending destination to the hazard unit and squashes stale port-B results on write-after-write.

Parameters:
- STARVE_LIMIT, 4, number of consecutive denied cycles for a buffered B result before a forced drain (must be ≥1).
- CNT_W, 3, starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wb_we  in  1  pipeline writeback request
- wb_waddr  in  `RegAddrBus  pipeline destination register
- wb_wdata  in  `RegBus  pipeline result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  arbiter can accept a long-latency result
- lu_waddr  in  `RegAddrBus  long-latency destination register
- lu_wdata  in  `RegBus  long-latency result
- rf_we  out  1  to regfile we
- rf_waddr  out  `RegAddrBus  to regfile waddr
- rf_wdata  out  `RegBus  to regfile wdata
- stall_o  out  1  freeze MEM/WB stage this cycle
- pend_valid  out  1  buffered B result not yet written
- pend_addr  out  `RegAddrBus  destination of buffered B result

Behaviour:
- Reset, cycle with rst=1:
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall_o=0, lu_ready=0, pend_valid=0, pend_addr=0.
  - State goes to IDLE, counter=0, buffer cleared.
  - Reset mid-operation discards any buffered result; it is never written.
- States:
  - IDLE: buffer empty.
  - PEND: buffer full.
  - FORCE: forced drain.
  - State and buffer are registered. rf_*, stall_o and lu_ready are combinational from state and inputs, so port A writes reach the regfile in the same cycle with no added latency.
- IDLE:
  - lu_ready=1; rf_* passes port A (rf_we=wb_we); stall_o=0.
  - lu_valid=1: capture lu_waddr/lu_wdata, counter=0, next state PEND.
  - If lu_waddr==0, discard the result and stay in IDLE (x0 never consumes the port).
- PEND:
  - lu_ready=0; pend_valid=1; pend_addr=buffer address.
  - wb_we=0: rf_* takes the buffer (rf_we=1). Next state IDLE.
  - wb_we=1 and wb_waddr==pend_addr: port A wins and the buffer is squashed, because the younger write owns the register. Next state IDLE, buffer not written.
  - wb_we=1, other address: port A wins and the counter increments. When the incremented value equals STARVE_LIMIT, next state is FORCE; otherwise stay in PEND.
- FORCE:
  - stall_o=1; rf_* takes the buffer (rf_we=1); wb_* is ignored this cycle.
  - The pipeline holds its request and re-presents it next cycle.
  - Next state IDLE, counter=0; pend_valid=1 during this cycle.
- Throughput and latency:
  - Port B has at most one result per 2 cycles; lu_ready is never 1 in the cycle the buffer drains.
  - Minimum B latency is accept at edge N, written to the regfile in cycle N+1.
- Invariants:
  - Exactly one source drives rf_* per cycle.
  - rf_we=1 implies rf_waddr≠0 for port-B writes.
  - stall_o=1 only in FORCE.

Decomposition:
- Shared defines header supplies `RegAddrBus, `RegBus, `RegNumLog2, `Enable/`Disable, `ZeroWord. Add `WbArbIdle/`WbArbPend/`WbArbForce 2-bit state codes there.
- No sub-module. The buffer, counter and FSM live in one file, instantiated alongside the regfile in the top-level.

Test Plan:
- Reset mid-PEND: buffer x5=0xDEADBEEF, assert rst for 1 cycle. -> rf_we=0, pend_valid=0, lu_ready=0 during reset, lu_ready=1 after. x5 is never written.
- Idle drain: lu_valid with x7=0x1234, wb_we=0 next cycle. -> cycle N+1: rf_we=1, rf_waddr=7, rf_wdata=0x1234, stall_o=0; then back to IDLE with lu_ready=1.
- Port-A priority: x3 buffered, wb_we=1 to x9=0x55 for 2 cycles, then wb_we=0. -> x9 written twice with no stall; x3 written in cycle 3; counter never reaches the limit.
- Starvation, STARVE_LIMIT=4: x3 buffered, wb_we=1 continuously to x10. -> 4 A writes, then one cycle with stall_o=1, rf_waddr=3, and the x10 write suppressed. The next cycle writes x10 again.
- WAW squash: x8=0xAAAA buffered, wb_we=1 to x8=0xBBBB. -> rf writes x8=0xBBBB only; pend_valid=0 next cycle; 0xAAAA is never written.
- x0 discard: lu_valid with waddr=0. -> state stays IDLE, pend_valid=0, lu_ready=1 next cycle, no rf_we from port B.
